// File: rtl/gpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : gpu_mem_responder
// Brief   : Avalon-MM byte slave backed by on-chip byte RAM, with a scanout
//           read port. GPU_RESP_RAND_STALL_EN adds LFSR-driven wait cycles.
// Revision: 1.0  initial release
// ============================================================================
module gpu_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          DEPTH      = 4096,
  parameter int          ADDR_BITS  = $clog2(DEPTH),
  parameter int          RD_LATENCY = 2,
  parameter int          WR_LATENCY = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          s1_address,
  input  logic                 s1_read,
  input  logic                 s1_write,
  input  logic [7:0]           s1_writedata,
  output logic [7:0]           s1_readdata,
  output logic                 s1_readdatavalid,
  output logic                 s1_waitrequest,
  input  logic [ADDR_BITS-1:0] scan_address,
  output logic [7:0]           scan_readdata,
  output logic [15:0]          err_count
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RD_WAIT = 3'd1;
  localparam logic [2:0] c_RD_RESP = 3'd2;
  localparam logic [2:0] c_WR_WAIT = 3'd3;
  localparam logic [2:0] c_WR_ACK  = 3'd4;

  localparam logic [4:0] c_RD_CNT = 5'(RD_LATENCY - 1);
  localparam logic [4:0] c_WR_CNT = (WR_LATENCY == 0) ? 5'd0 : 5'(WR_LATENCY - 1);

  logic [4:0] w_extra;

`ifdef GPU_RESP_RAND_STALL_EN
  // Zero-latency writes also take the slow path so they can be stalled.
  localparam bit c_WR_FAST = 1'b0;
  logic [15:0] r_lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_extra = {3'b000, r_lfsr[1:0]};
`else
  localparam bit c_WR_FAST = (WR_LATENCY == 0);
  assign w_extra = 5'd0;
`endif

  logic [7:0]           r_ram [DEPTH];
  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic [4:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_idx;
  logic [7:0]           r_data;
  logic                 r_in_range;
  logic [7:0]           r_rd_q;
  logic [7:0]           r_scan_q;
  logic [15:0]          r_err;

  logic [31:0]          w_off;
  logic                 w_in_range;
  logic [ADDR_BITS-1:0] w_in_idx;
  logic [ADDR_BITS-1:0] w_rd_idx;
  logic [4:0]           w_rd_load;
  logic [4:0]           w_wr_load;
  logic                 w_idle;
  logic                 w_accept_wr;
  logic                 w_fast_wr;
  logic                 w_slow_wr;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_widx;
  logic [7:0]           w_wdata;
  logic                 w_err_inc;

  // Unsigned offset wraps for addresses below the base, so one compare covers both ends.
  assign w_off      = s1_address - BASE_ADDR;
  assign w_in_range = (s1_address >= BASE_ADDR) && (w_off < 32'(DEPTH));
  assign w_in_idx   = w_off[ADDR_BITS-1:0];

  assign w_rd_load   = c_RD_CNT + w_extra;
  assign w_wr_load   = c_WR_CNT + w_extra;
  assign w_idle      = (r_state == c_IDLE);
  assign w_accept_wr = w_idle && s1_write && !s1_read;
  assign w_fast_wr   = w_accept_wr && c_WR_FAST;
  assign w_slow_wr   = w_accept_wr && !c_WR_FAST;
  assign w_rd_idx    = w_idle ? w_in_idx : r_idx;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (s1_read)
          w_next_state = (w_rd_load == 5'd0) ? c_RD_RESP : c_RD_WAIT;
        else if (s1_write && !c_WR_FAST)
          w_next_state = (w_wr_load == 5'd0) ? c_WR_ACK : c_WR_WAIT;
      end
      c_RD_WAIT: if (r_cnt <= 5'd1) w_next_state = c_RD_RESP;
      c_RD_RESP: w_next_state = c_IDLE;
      c_WR_WAIT: if (r_cnt <= 5'd1) w_next_state = c_WR_ACK;
      c_WR_ACK:  w_next_state = c_IDLE;
      default:   w_next_state = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s1_waitrequest   = 1'b0;
    s1_readdatavalid = 1'b0;
    s1_readdata      = 8'h00;
    case (r_state)
      c_IDLE:    s1_waitrequest = s1_read || (s1_write && !c_WR_FAST);
      c_RD_WAIT: s1_waitrequest = 1'b1;
      c_WR_WAIT: s1_waitrequest = 1'b1;
      c_RD_RESP: begin
        s1_readdatavalid = 1'b1;
        s1_readdata      = r_in_range ? r_rd_q : 8'h00;
      end
      default: ;
    endcase
  end

  // Transaction latches, wait counter and read registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= 5'd0;
      r_idx      <= '0;
      r_data     <= 8'h00;
      r_in_range <= 1'b0;
      r_rd_q     <= 8'h00;
      r_scan_q   <= 8'h00;
    end else begin
      r_rd_q   <= r_ram[w_rd_idx];
      r_scan_q <= r_ram[scan_address];
      if (w_idle && (s1_read || s1_write)) begin
        r_idx      <= w_in_idx;
        r_data     <= s1_writedata;
        r_in_range <= w_in_range;
      end
      if (w_idle && s1_read)
        r_cnt <= w_rd_load;
      else if (w_slow_wr)
        r_cnt <= w_wr_load;
      else if ((r_state == c_RD_WAIT) || (r_state == c_WR_WAIT))
        r_cnt <= r_cnt - 5'd1;
    end
  end

  // Reset gates the write so a write caught by reset is never committed.
  assign w_we    = !reset && ((w_fast_wr && w_in_range) || ((r_state == c_WR_ACK) && r_in_range));
  assign w_widx  = w_fast_wr ? w_in_idx : r_idx;
  assign w_wdata = w_fast_wr ? s1_writedata : r_data;

  always_ff @(posedge clock) begin
    if (w_we) r_ram[w_widx] <= w_wdata;
  end

  assign w_err_inc = (w_idle && s1_read && s1_write)
                  || ((r_state == c_RD_RESP) && !r_in_range)
                  || (w_fast_wr && !w_in_range)
                  || ((r_state == c_WR_ACK) && !r_in_range);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              r_err <= 16'h0000;
    else if (w_err_inc && r_err != 16'hFFFF) r_err <= r_err + 16'h0001;
  end

  assign scan_readdata = r_scan_q;
  assign err_count     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpu_mem_responder
// Brief   : Randomized scoreboard bench for gpu_mem_responder (default build).
// Revision: 1.0  initial release
// ============================================================================
module tb_gpu_mem_responder;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          DEPTH  = 256;
  localparam int          AB     = 8;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   s1_address = '0;
  logic          s1_read = 1'b0;
  logic          s1_write = 1'b0;
  logic [7:0]    s1_writedata = '0;
  logic [7:0]    s1_readdata;
  logic          s1_readdatavalid;
  logic          s1_waitrequest;
  logic [AB-1:0] scan_address = '0;
  logic [7:0]    scan_readdata;
  logic [15:0]   err_count;

  gpu_mem_responder #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .ADDR_BITS (AB),
    .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .s1_address      (s1_address),
    .s1_read         (s1_read),
    .s1_write        (s1_write),
    .s1_writedata    (s1_writedata),
    .s1_readdata     (s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest  (s1_waitrequest),
    .scan_address    (scan_address),
    .scan_readdata   (scan_readdata),
    .err_count       (err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    bit         known;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem_model [DEPTH];
  bit         mem_known [DEPTH];
  int         err_model = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a - BASE) % DEPTH;
  endfunction

  // Monitor: every read completion pops the oldest expectation.
  always @(negedge clock) begin
    if (s1_readdatavalid) begin
      check("rdv_with_waitreq", {31'b0, s1_waitrequest}, 32'd0);
      if (sb.size() == 0) begin
        check("rdv_unexpected", {31'b0, s1_readdatavalid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.known) check("rd_data", {24'b0, s1_readdata}, {24'b0, e.data});
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input bit also_wr, input logic [7:0] wd);
    exp_t e;
    int   waits;
    if (also_wr) err_model++;
    if (in_rng(a)) begin
      e.data  = mem_model[idx_of(a)];
      e.known = mem_known[idx_of(a)];
    end else begin
      e.data  = 8'h00;
      e.known = 1'b1;
      err_model++;
    end
    sb.push_back(e);
    s1_address   = a;
    s1_writedata = wd;
    s1_read      = 1'b1;
    s1_write     = also_wr;
    waits        = 0;
    @(negedge clock);
    while (s1_waitrequest && waits < 40) begin
      waits++;
      @(negedge clock);
      if (s1_waitrequest) begin
        s1_address   = $urandom;
        s1_writedata = 8'($urandom);
      end
    end
    check("rd_latency", waits, RD_LAT);
    @(posedge clock); #1;
    s1_read  = 1'b0;
    s1_write = 1'b0;
    check("err_after_rd", {16'b0, err_count}, err_model);
  endtask

  // Leaves s1_write asserted so callers can issue back-to-back writes.
  task automatic do_write(input logic [31:0] a, input logic [7:0] d);
    s1_address   = a;
    s1_writedata = d;
    s1_write     = 1'b1;
    s1_read      = 1'b0;
    @(negedge clock);
    check("wr_waitreq", {31'b0, s1_waitrequest}, 32'd0);
    if (in_rng(a)) begin
      mem_model[idx_of(a)] = d;
      mem_known[idx_of(a)] = 1'b1;
    end else begin
      err_model++;
    end
    @(posedge clock); #1;
  endtask

  task automatic scan_check(input int idx);
    scan_address = AB'(idx);
    @(posedge clock);
    @(negedge clock);
    if (mem_known[idx]) check("scan_data", {24'b0, scan_readdata}, {24'b0, mem_model[idx]});
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] pick_addr();
    int sel;
    sel = $urandom_range(0, 19);
    case (sel)
      0:       return BASE - 32'd1;
      1:       return BASE + 32'(DEPTH);
      2:       return BASE;
      3:       return BASE + 32'(DEPTH) - 32'd1;
      4:       return $urandom;
      default: return BASE + 32'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  old;
    int          kind;
    int          burst;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) mem_known[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_rdv",     {31'b0, s1_readdatavalid}, 32'd0);
    check("rst_rdata",   {24'b0, s1_readdata}, 32'd0);
    check("rst_waitreq", {31'b0, s1_waitrequest}, 32'd0);
    check("rst_scan",    {24'b0, scan_readdata}, 32'd0);
    check("rst_err",     {16'b0, err_count}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Preload then timed read
    do_write(BASE + 32'd5, 8'h3C);
    s1_write = 1'b0;
    do_read(BASE + 32'd5, 1'b0, 8'h00);

    // Back-to-back zero-latency writes, read-back and scanout
    do_write(BASE + 32'd0, 8'h11);
    do_write(BASE + 32'd1, 8'h22);
    do_write(BASE + 32'd2, 8'h33);
    s1_write = 1'b0;
    for (int i = 0; i < 3; i++) do_read(BASE + 32'(i), 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) scan_check(i);

    // Scan read colliding with a same-index write returns the old byte
    old          = mem_model[1];
    scan_address = AB'(1);
    do_write(BASE + 32'd1, 8'h5A);
    s1_write = 1'b0;
    @(negedge clock);
    check("scan_old", {24'b0, scan_readdata}, {24'b0, old});
    @(negedge clock);
    check("scan_new", {24'b0, scan_readdata}, 32'h5A);
    @(posedge clock); #1;

    // Out-of-range accesses at both boundaries
    do_read(BASE + 32'(DEPTH), 1'b0, 8'h00);
    check("err_oor_rd", {16'b0, err_count}, 32'd1);
    do_write(BASE - 32'd1, 8'hEE);
    s1_write = 1'b0;
    check("err_oor_wr", {16'b0, err_count}, 32'd2);
    do_read(BASE + 32'(DEPTH) - 32'd1, 1'b0, 8'h00);

    // Read and write together: read wins, write dropped
    do_read(BASE + 32'd2, 1'b1, 8'h99);
    do_read(BASE + 32'd2, 1'b0, 8'h00);

    // Reset while waiting on a read
    s1_address = BASE + 32'd5;
    s1_read    = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b1;
    s1_read = 1'b0;
    #1;
    check("rst_mid_rdv",     {31'b0, s1_readdatavalid}, 32'd0);
    check("rst_mid_waitreq", {31'b0, s1_waitrequest}, 32'd0);
    @(posedge clock); #1;
    reset     = 1'b0;
    err_model = 0;
    repeat (4) @(posedge clock);
    #1;
    check("rst_mid_err", {16'b0, err_count}, 32'd0);
    do_read(BASE + 32'd5, 1'b0, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a    = pick_addr();
      if (kind < 4) begin
        do_read(a, 1'b0, 8'h00);
      end else if (kind < 9) begin
        burst = $urandom_range(1, 3);
        for (int b = 0; b < burst; b++) begin
          do_write(a, 8'($urandom));
          a = pick_addr();
        end
        s1_write = 1'b0;
        check("err_after_wr", {16'b0, err_count}, err_model);
      end else begin
        do_read(a, 1'b1, 8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) scan_check($urandom_range(0, DEPTH - 1));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    repeat (5) @(posedge clock);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    check("err_final", {16'b0, err_count}, err_model);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
